// File: rtl/cdp1802_dma_responder.sv
// CDP1802 machine-cycle sequencer: fetch/execute/DMA-out/interrupt state codes,
// 8-tick cycle timing, R0-addressed DMA-out byte delivery and interrupt acknowledge.
module cdp1802_dma_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        dma_out_n,
  input  logic        int_req,
  input  logic        exec_extend,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  mem_data_in,
  input  logic        ie_set,
  input  logic        ie_clr,
  input  logic        r0_load,
  input  logic [15:0] r0_load_value,
  output logic [1:0]  sc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  dma_data,
  output logic        dma_strobe,
  output logic [15:0] r0_value,
  output logic        ie,
  output logic        int_ack,
  output logic [2:0]  tick
);

  typedef enum logic [1:0] {
    S0_FETCH = 2'b00,
    S1_EXEC  = 2'b01,
    S2_DMA   = 2'b10,
    S3_INT   = 2'b11
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_tick;
  logic [15:0] r_r0;
  logic        r_ie;
  logic [7:0]  r_dma_data;
  logic        r_dma_strobe;
  logic        r_int_ack;

  logic w_boundary, w_dma_xfer, w_int_take;

  assign w_boundary = clk_enable && (r_tick == 3'd7);
  assign w_dma_xfer = clk_enable && (r_tick == 3'd6) && (r_state == S2_DMA);
  assign w_int_take = clk_enable && (r_tick == 3'd6) && (r_state == S3_INT);

  // Requests are only looked at on the boundary, so mid-cycle glitches never count.
  always_comb begin
    w_state_nxt = r_state;
    if (w_boundary) begin
      unique case (r_state)
        S0_FETCH: w_state_nxt = S1_EXEC;
        S1_EXEC: begin
          if (!dma_out_n)          w_state_nxt = S2_DMA;
          else if (int_req && r_ie) w_state_nxt = S3_INT;
          else if (exec_extend)    w_state_nxt = S1_EXEC;
          else                     w_state_nxt = S0_FETCH;
        end
        S2_DMA: begin
          if (!dma_out_n)          w_state_nxt = S2_DMA;
          else if (int_req && r_ie) w_state_nxt = S3_INT;
          else                     w_state_nxt = S0_FETCH;
        end
        S3_INT: begin
          if (!dma_out_n)          w_state_nxt = S2_DMA;
          else                     w_state_nxt = S0_FETCH;
        end
        default:                   w_state_nxt = S0_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S1_EXEC;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick       <= 3'd0;
      r_r0         <= 16'h0000;
      r_ie         <= 1'b1;
      r_dma_data   <= 8'h00;
      r_dma_strobe <= 1'b0;
      r_int_ack    <= 1'b0;
    end else begin
      r_dma_strobe <= w_dma_xfer;
      r_int_ack    <= w_int_take;
      if (clk_enable) begin
        r_tick <= r_tick + 3'd1;
        if (r0_load)         r_r0 <= r0_load_value;
        else if (w_dma_xfer) r_r0 <= r_r0 + 16'd1;
        if (w_dma_xfer) r_dma_data <= mem_data_in;
        // Interrupt entry and ie_clr both beat a simultaneous ie_set.
        if (w_int_take || ie_clr) r_ie <= 1'b0;
        else if (ie_set)          r_ie <= 1'b1;
      end
    end
  end

  assign sc         = r_state;
  assign tick       = r_tick;
  assign mem_addr   = (r_state == S2_DMA) ? r_r0 : cpu_addr;
  assign mem_rd     = (r_state == S2_DMA) && (r_tick >= 3'd1) && (r_tick <= 3'd5);
  assign dma_data   = r_dma_data;
  assign dma_strobe = r_dma_strobe;
  assign r0_value   = r_r0;
  assign ie         = r_ie;
  assign int_ack    = r_int_ack;

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Directed bench for cdp1802_dma_responder: state sequencing, DMA bursts,
// R0 wrap, interrupt entry, mid-cycle reset and clk_enable stalls.
module tb_cdp1802_dma_responder;

  logic        clk = 1'b0;
  logic        reset, clk_enable, dma_out_n, int_req, exec_extend;
  logic [15:0] cpu_addr;
  logic [7:0]  mem_data_in;
  logic        ie_set, ie_clr, r0_load;
  logic [15:0] r0_load_value;
  logic [1:0]  sc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  dma_data;
  logic        dma_strobe;
  logic [15:0] r0_value;
  logic        ie, int_ack;
  logic [2:0]  tick;

  int n_checks = 0;
  int n_fail   = 0;

  cdp1802_dma_responder dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .dma_out_n(dma_out_n),
    .int_req(int_req), .exec_extend(exec_extend), .cpu_addr(cpu_addr),
    .mem_data_in(mem_data_in), .ie_set(ie_set), .ie_clr(ie_clr), .r0_load(r0_load),
    .r0_load_value(r0_load_value), .sc(sc), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .dma_data(dma_data), .dma_strobe(dma_strobe), .r0_value(r0_value), .ie(ie),
    .int_ack(int_ack), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_enable = 1'b1; dma_out_n = 1'b1; int_req = 1'b0;
    exec_extend = 1'b0; ie_set = 1'b0; ie_clr = 1'b0; r0_load = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cpu_addr = 16'hBEEF; mem_data_in = 8'h00; r0_load_value = 16'h0000;
    reset = 1'b1; clk_enable = 1'b0; dma_out_n = 1'b1; int_req = 1'b0;
    exec_extend = 1'b0; ie_set = 1'b0; ie_clr = 1'b0; r0_load = 1'b0;
    step(2);
    reset = 1'b0; clk_enable = 1'b1;
    n_checks++;
    if ({sc, tick, r0_value, ie, dma_data, dma_strobe, int_ack, mem_rd} !==
        {2'b01, 3'd0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: sc=%b tick=%0d r0=%h ie=%b dd=%h st=%b ack=%b rd=%b",
               sc, tick, r0_value, ie, dma_data, dma_strobe, int_ack, mem_rd);
    end
    n_checks++;
    if (mem_addr !== 16'hBEEF) begin
      n_fail++; $display("FAIL reset_mem_addr: got %h want BEEF", mem_addr);
    end
  endtask

  task automatic test_idle();
    logic [1:0] exp_sc [4];
    int rd_seen;
    exp_sc[0] = 2'b01; exp_sc[1] = 2'b00; exp_sc[2] = 2'b01; exp_sc[3] = 2'b00;
    do_reset();
    rd_seen = 0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (sc !== exp_sc[c] || tick !== 3'd0) begin
        n_fail++; $display("FAIL idle_sc[%0d]: got sc=%b tick=%0d want %b tick 0", c, sc, tick, exp_sc[c]);
      end
      for (int t = 0; t < 8; t++) begin
        if (mem_rd !== 1'b0) rd_seen++;
        step(1);
      end
    end
    n_checks++;
    if (rd_seen != 0) begin
      n_fail++; $display("FAIL idle_mem_rd: asserted %0d ticks want 0", rd_seen);
    end
  endtask

  task automatic test_exec_extend();
    do_reset();
    exec_extend = 1'b1;
    step(8);
    n_checks++;
    if (sc !== 2'b01) begin n_fail++; $display("FAIL exec_extend_hold: sc=%b want 01", sc); end
    exec_extend = 1'b0;
    step(8);
    n_checks++;
    if (sc !== 2'b00) begin n_fail++; $display("FAIL exec_extend_release: sc=%b want 00", sc); end
  endtask

  task automatic test_dma_burst();
    int strobes, rd_bad;
    logic [7:0] last_byte;
    do_reset();
    r0_load = 1'b1; r0_load_value = 16'h0900;
    step(1);
    r0_load = 1'b0; dma_out_n = 1'b0;
    step(7);
    strobes = 0; rd_bad = 0; last_byte = 8'h00;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) dma_out_n = 1'b1;
      mem_data_in = 8'h40 + 8'(c);
      n_checks++;
      if (sc !== 2'b10 || mem_addr !== 16'h0900 + 16'(c)) begin
        n_fail++; $display("FAIL dma_burst_addr[%0d]: sc=%b addr=%h want 10 %h", c, sc, mem_addr, 16'h0900 + 16'(c));
      end
      for (int t = 0; t < 8; t++) begin
        if (mem_rd !== (t >= 1 && t <= 5)) rd_bad++;
        step(1);
        if (dma_strobe === 1'b1) begin strobes++; last_byte = dma_data; end
      end
    end
    n_checks++;
    if (rd_bad != 0) begin n_fail++; $display("FAIL dma_burst_mem_rd: %0d wrong ticks want 0", rd_bad); end
    n_checks++;
    if (strobes != 8) begin n_fail++; $display("FAIL dma_burst_strobes: got %0d want 8", strobes); end
    n_checks++;
    if (last_byte !== 8'h47) begin n_fail++; $display("FAIL dma_burst_data: got %h want 47", last_byte); end
    n_checks++;
    if (r0_value !== 16'h0908 || sc !== 2'b00) begin
      n_fail++; $display("FAIL dma_burst_end: r0=%h sc=%b want 0908 00", r0_value, sc);
    end
  endtask

  task automatic test_r0_wrap();
    do_reset();
    r0_load = 1'b1; r0_load_value = 16'hFFFF;
    step(1);
    r0_load = 1'b0; dma_out_n = 1'b0;
    step(7);
    dma_out_n = 1'b1; mem_data_in = 8'hA5;
    n_checks++;
    if (mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr: got %h want FFFF", mem_addr); end
    step(7);
    n_checks++;
    if (dma_strobe !== 1'b1 || dma_data !== 8'hA5 || r0_value !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_xfer: st=%b dd=%h r0=%h want 1 A5 0000", dma_strobe, dma_data, r0_value);
    end
    step(1);
    n_checks++;
    if (dma_strobe !== 1'b0 || sc !== 2'b00) begin
      n_fail++; $display("FAIL wrap_after: st=%b sc=%b want 0 00", dma_strobe, sc);
    end
  endtask

  task automatic test_interrupt();
    do_reset();
    dma_out_n = 1'b0; int_req = 1'b1;
    step(8);
    n_checks++;
    if (sc !== 2'b10) begin n_fail++; $display("FAIL int_dma_first: sc=%b want 10", sc); end
    dma_out_n = 1'b1;
    step(8);
    n_checks++;
    if (sc !== 2'b11) begin n_fail++; $display("FAIL int_enter: sc=%b want 11", sc); end
    step(6);
    n_checks++;
    if (int_ack !== 1'b0 || ie !== 1'b1) begin
      n_fail++; $display("FAIL int_pre_ack: ack=%b ie=%b want 0 1", int_ack, ie);
    end
    step(1);
    n_checks++;
    if (int_ack !== 1'b1 || ie !== 1'b0) begin
      n_fail++; $display("FAIL int_ack_pulse: ack=%b ie=%b want 1 0", int_ack, ie);
    end
    step(1);
    n_checks++;
    if (int_ack !== 1'b0 || sc !== 2'b00) begin
      n_fail++; $display("FAIL int_exit: ack=%b sc=%b want 0 00", int_ack, sc);
    end
    step(16);
    n_checks++;
    if (sc !== 2'b00) begin n_fail++; $display("FAIL int_masked: sc=%b want 00", sc); end
    ie_set = 1'b1;
    step(1);
    ie_set = 1'b0;
    n_checks++;
    if (ie !== 1'b1) begin n_fail++; $display("FAIL int_ie_set: ie=%b want 1", ie); end
    step(15);
    n_checks++;
    if (sc !== 2'b11) begin n_fail++; $display("FAIL int_reenter: sc=%b want 11", sc); end
    int_req = 1'b0;
    step(6);
    ie_set = 1'b1;
    step(1);
    ie_set = 1'b0;
    n_checks++;
    if (ie !== 1'b0 || int_ack !== 1'b1) begin
      n_fail++; $display("FAIL int_clear_beats_set: ie=%b ack=%b want 0 1", ie, int_ack);
    end
  endtask

  task automatic test_reset_mid_dma();
    do_reset();
    dma_out_n = 1'b0;
    step(8);
    step(3);
    n_checks++;
    if (sc !== 2'b10 || tick !== 3'd3) begin
      n_fail++; $display("FAIL midreset_setup: sc=%b tick=%0d want 10 3", sc, tick);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0; dma_out_n = 1'b1;
    n_checks++;
    if (sc !== 2'b01 || tick !== 3'd0 || dma_strobe !== 1'b0 || r0_value !== 16'h0000) begin
      n_fail++; $display("FAIL midreset: sc=%b tick=%0d st=%b r0=%h want 01 0 0 0000", sc, tick, dma_strobe, r0_value);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    dma_out_n = 1'b0;
    step(8);
    dma_out_n = 1'b1;
    step(6);
    r0_load = 1'b1; r0_load_value = 16'h1234;
    step(1);
    r0_load = 1'b0;
    n_checks++;
    if (r0_value !== 16'h1234 || dma_strobe !== 1'b1) begin
      n_fail++; $display("FAIL load_priority: r0=%h st=%b want 1234 1", r0_value, dma_strobe);
    end
  endtask

  task automatic test_clk_enable_hold();
    do_reset();
    dma_out_n = 1'b0;
    step(8);
    dma_out_n = 1'b1;
    step(6);
    clk_enable = 1'b0;
    step(3);
    n_checks++;
    if (tick !== 3'd6 || dma_strobe !== 1'b0 || r0_value !== 16'h0000 || sc !== 2'b10) begin
      n_fail++; $display("FAIL stall_hold: tick=%0d st=%b r0=%h sc=%b want 6 0 0000 10", tick, dma_strobe, r0_value, sc);
    end
    clk_enable = 1'b1;
    step(1);
    clk_enable = 1'b0;
    n_checks++;
    if (dma_strobe !== 1'b1 || r0_value !== 16'h0001) begin
      n_fail++; $display("FAIL stall_xfer: st=%b r0=%h want 1 0001", dma_strobe, r0_value);
    end
    step(1);
    n_checks++;
    if (dma_strobe !== 1'b0 || tick !== 3'd7 || sc !== 2'b10) begin
      n_fail++; $display("FAIL stall_strobe_drop: st=%b tick=%0d sc=%b want 0 7 10", dma_strobe, tick, sc);
    end
    ie_set = 1'b1; ie_clr = 1'b1;
    step(1);
    n_checks++;
    if (ie !== 1'b1) begin n_fail++; $display("FAIL stall_ie_hold: ie=%b want 1", ie); end
    clk_enable = 1'b1;
    step(1);
    ie_set = 1'b0; ie_clr = 1'b0;
    n_checks++;
    if (ie !== 1'b0 || sc !== 2'b00) begin
      n_fail++; $display("FAIL ie_clr_wins: ie=%b sc=%b want 0 00", ie, sc);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_exec_extend();
    test_dma_burst();
    test_r0_wrap();
    test_interrupt();
    test_reset_mid_dma();
    test_load_priority();
    test_clk_enable_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdp1802_dma_responder.md
CDP1802_DMA_RESPONDER -- requirements
Module: cdp1802_dma_responder

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk regardless of clk_enable.
REQ-003 SHALL have port clk_enable  input  1  CPU tick strobe; every state change other than reset requires clk_enable=1.
REQ-004 SHALL have port dma_out_n  input  1  active-low DMA-out request from the video generator.
REQ-005 SHALL have port int_req  input  1  active-high interrupt request.
REQ-006 SHALL have port exec_extend  input  1  CPU core requests one more execute cycle (long instruction).
REQ-007 SHALL have port cpu_addr  input  16  address the CPU core drives in S0/S1.
REQ-008 SHALL have port mem_data_in  input  8  memory read data.
REQ-009 SHALL have ports ie_set, ie_clr, r0_load  input  1 each  and r0_load_value  input  16  CPU register controls.
REQ-010 SHALL have port sc  output  2  state code: 00 fetch, 01 execute, 10 DMA, 11 interrupt.
REQ-011 SHALL have ports mem_addr  output  16  and mem_rd  output  1  memory address and read strobe.
REQ-012 SHALL have ports dma_data  output  8  and dma_strobe  output  1  byte delivered to the video generator with a one-clk valid pulse.
REQ-013 SHALL have ports r0_value  output  16,  ie  output  1,  int_ack  output  1 (one-clk pulse),  tick  output  3.

Function
REQ-014 SHALL count tick 0..7 per machine cycle, advancing on clk_enable and wrapping 7->0; the cycle boundary is tick=7 with clk_enable=1.
REQ-015 SHALL hold state S0..S3 (encoding = sc) and change it only at the cycle boundary.
REQ-016 SHALL sample dma_out_n and int_req only at the cycle boundary; intermediate pulses are ignored.
REQ-017 SHALL transition S0 -> S1 unconditionally.
REQ-018 SHALL transition from S1: dma_out_n=0 -> S2; else int_req=1 and ie=1 -> S3; else exec_extend=1 -> S1; else S0.
REQ-019 SHALL transition from S2: dma_out_n=0 -> S2; else int_req=1 and ie=1 -> S3; else S0.
REQ-020 SHALL transition from S3: dma_out_n=0 -> S2; else S0.
REQ-021 SHALL drive mem_addr = R0 in S2 and mem_addr = cpu_addr in all other states, combinationally.
REQ-022 SHALL assert mem_rd during ticks 1..5 of S2 only.
REQ-023 SHALL, in S2 at tick 6 with clk_enable, register dma_data <= mem_data_in, pulse dma_strobe for exactly one clk, and increment R0 modulo 2^16 (FFFF -> 0000).
REQ-024 SHALL, in S3 at tick 6 with clk_enable, clear ie and pulse int_ack for exactly one clk.
REQ-025 SHALL apply ie_set/ie_clr on clk_enable in any state; ie_clr wins over ie_set; S3 clear wins over ie_set.
REQ-026 SHALL apply r0_load on clk_enable; r0_load wins over the S2 tick-6 increment in the same clk.
REQ-027 SHALL expose r0_value = R0 at all times.
REQ-028 SHALL hold all registers when clk_enable=0, except that dma_strobe and int_ack deassert on the next clk.

Reset
REQ-029 SHALL, on reset, set state S1 (sc=01), tick=0, R0=0000, ie=1, dma_data=00, dma_strobe=0, int_ack=0; mem_rd therefore reads 0.
REQ-030 SHALL abort any in-progress DMA or interrupt cycle on reset mid-cycle, with no dma_strobe, no int_ack and no R0 increment.

Verification
REQ-031 Reset, dma_out_n=1, int_req=0 -> sc sequence 01,00,01,00 at 8-tick cycles; mem_rd never 1.
REQ-032 R0 loaded 0900, dma_out_n=0 held for 8 boundaries after S1 -> 8 S2 cycles, dma_strobe 8 times, mem_addr 0900..0907, final R0=0908, then S0.
REQ-033 R0 loaded FFFF, one DMA cycle with mem_data_in=A5 -> dma_data=A5, R0=0000.
REQ-034 int_req=1 and dma_out_n=0 at the same S1 boundary -> S2 first, then S3 with int_ack pulse and ie=0, then S0; a second int_req is ignored until ie_set.
REQ-035 reset asserted at tick 3 of S2 -> next clk sc=01, tick=0, no dma_strobe, R0=0000.
REQ-036 r0_load=1 with value 1234 at S2 tick 6 -> R0=1234 (not incremented), dma_strobe still pulses.
